lzc_normalizer_pipe: RTL

//   Normalization stage fed by the leading-zero counter.

---
 rtl/lzc_normalizer_pipe.sv | 116 +++++++++++
 1 files changed

// File: rtl/lzc_normalizer_pipe.sv
// Two-stage normalizer: shifts a word left by its leading-zero count and emits exponent + zero flag.
// Optional `LZ_CHECK_EN adds a count checker that drives lz_err; otherwise lz_err is tied 0.
module lzc_normalizer_pipe #(
    parameter int WIDTH    = 8,
    parameter int CW       = 4,
    parameter int EXP_W    = 5,
    parameter int EXP_BIAS = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CW-1:0]    in_lz,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_mant,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lz_err
);

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_data;
    logic [CW-1:0]    r_s1_lz;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_mant;
    logic [EXP_W-1:0] r_out_exp;
    logic             r_out_zero;

    logic             w_adv2;
    logic             w_in_xfer;
    logic [CW-1:0]    w_lz_clamped;
    logic             w_s1_zero;
    logic [EXP_W-1:0] w_s1_exp;

    assign w_adv2       = !r_out_valid || out_ready;
    assign in_ready     = !r_s1_valid || w_adv2;
    assign w_in_xfer    = in_valid && in_ready;
    assign w_lz_clamped = (in_lz > CW'(WIDTH)) ? CW'(WIDTH) : in_lz;

    assign w_s1_zero = (r_s1_lz == CW'(WIDTH));
    // Exponent wraps modulo 2^EXP_W by construction of the EXP_W-wide subtraction.
    assign w_s1_exp  = w_s1_zero ? '0
                                 : EXP_W'(EXP_BIAS + WIDTH - 1) - EXP_W'(r_s1_lz);

    // S1: capture word and clamped count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_in_xfer) begin
            r_s1_valid <= 1'b1;
        end else if (w_adv2) begin
            r_s1_valid <= 1'b0;
        end
    end

    // NOTE: payload registers are not reset; only the valid bit gates their use.
    always_ff @(posedge clk) begin
        if (w_in_xfer) begin
            r_s1_data <= in_data;
            r_s1_lz   <= w_lz_clamped;
        end
    end

    // S2: registered outputs, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_mant  <= '0;
            r_out_exp   <= '0;
            r_out_zero  <= 1'b0;
        end else if (w_adv2) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_mant <= r_s1_data << r_s1_lz;
                r_out_exp  <= w_s1_exp;
                r_out_zero <= w_s1_zero;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_mant  = r_out_mant;
    assign out_exp   = r_out_exp;
    assign out_zero  = r_out_zero;

`ifdef LZ_CHECK_EN
    logic [CW-1:0] w_true_lz;
    logic          r_lz_err;

    // Scan LSB to MSB so the highest set bit decides the count.
    always_comb begin
        w_true_lz = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (r_s1_data[i]) begin
                w_true_lz = CW'(WIDTH - 1 - i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lz_err <= 1'b0;
        end else if (w_adv2 && r_s1_valid) begin
            r_lz_err <= (w_true_lz != r_s1_lz);
        end
    end

    assign lz_err = r_lz_err;
`else
    assign lz_err = 1'b0;
`endif

endmodule
